ram_arbiter: RTL and testbench

- Clocked two-requester controller in front of the 16x32 combinational `ram` block (w_en / address / data_input / data_output).
- Serialises read and write accesses from two independent masters using a round-robin arbiter and a 3-state sequencer.
- Holds address and data stable while w_en is high and registers read data.
- Returns a one-cycle ack per completed access.

---
 rtl/ram_ctrl_pkg.sv | 17 +
 rtl/arb_rr2.sv | 23 ++
 rtl/ram_arbiter.sv | 132 +++++++++++++
 tb/tb_ram_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the two-requester RAM controller.
// Sequencer state encoding and requester indices live here so the top and the picker agree.
package ram_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker.
// A lone requester always wins; on a tie the requester that was not granted last wins.
module arb_rr2
    import ram_ctrl_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = REQ0;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = REQ1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Clocked front end for a 16x32 combinational RAM shared by two requesters.
// IDLE -> ACCESS -> RESP sequencer: one access per three cycles, one-cycle ack per access.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_input,
    input  logic [DATA_W-1:0] ram_data_output
);

    state_t              state_q, state_d;
    logic                cur_q, cur_d;
    logic                last_grant_q, last_grant_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                w_en_q, w_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                grant_valid;
    logic                grant_winner;

    arb_rr2 u_arb (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .valid      (grant_valid),
        .winner     (grant_winner)
    );

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        last_grant_d = last_grant_q;
        ack0_d       = ack0_q;
        ack1_d       = ack1_q;
        rdata_d      = rdata_q;
        w_en_d       = w_en_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        case (state_q)
            ST_IDLE: begin
                // Address/data only move here, so they are frozen whenever w_en can be high.
                if (grant_valid) begin
                    cur_d = grant_winner;
                    if (grant_winner == REQ1) begin
                        addr_d  = addr1;
                        wdata_d = wdata1;
                        w_en_d  = we1;
                    end else begin
                        addr_d  = addr0;
                        wdata_d = wdata0;
                        w_en_d  = we0;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rdata_d      = ram_data_output;
                w_en_d       = 1'b0;
                ack0_d       = (cur_q == REQ0);
                ack1_d       = (cur_q == REQ1);
                last_grant_d = cur_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                w_en_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_q        <= REQ0;
            last_grant_q <= REQ1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata_q      <= '0;
            w_en_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata_q      <= rdata_d;
            w_en_q       <= w_en_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign rdata          = rdata_q;
    assign busy           = (state_q != ST_IDLE);
    assign ram_w_en       = w_en_q;
    assign ram_address    = addr_q;
    assign ram_data_input = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a behavioural 16x32 read-through RAM attached.
// Expected rdata per requester is queued when a request is issued and popped on its ack.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [3:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, ram_w_en;
    logic [31:0] rdata, ram_data_input, ram_data_output;
    logic [3:0]  ram_address;

    logic [31:0] mem [16];
    logic [31:0] shadow [16];
    logic [31:0] exp0_q [$];
    logic [31:0] exp1_q [$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req0            (req0),
        .we0             (we0),
        .addr0           (addr0),
        .wdata0          (wdata0),
        .req1            (req1),
        .we1             (we1),
        .addr1           (addr1),
        .wdata1          (wdata1),
        .ack0            (ack0),
        .ack1            (ack1),
        .rdata           (rdata),
        .busy            (busy),
        .ram_w_en        (ram_w_en),
        .ram_address     (ram_address),
        .ram_data_input  (ram_data_input),
        .ram_data_output (ram_data_output)
    );

    // Read-through RAM: a word being written appears on the output in the same cycle.
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_address] <= ram_data_input;
    end
    assign ram_data_output = ram_w_en ? ram_data_input : mem[ram_address];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic set_req(input int idx, input logic r, input logic we,
                           input logic [3:0] a, input logic [31:0] d);
        if (idx == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    // Issue one access, wait for its ack (bounded), then drop req on the edge after the ack.
    task automatic run_access(input int idx, input logic we, input logic [3:0] a,
                              input logic [31:0] d, output int lat);
        logic got;
        @(negedge clk);
        set_req(idx, 1'b1, we, a, d);
        if (we) shadow[a] = d;
        if (idx == 0) exp0_q.push_back(shadow[a]);
        else exp1_q.push_back(shadow[a]);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 32) begin
            @(posedge clk); #1;
            lat++;
            got = (idx == 0) ? ack0 : ack1;
        end
        if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        set_req(idx, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    // Monitor: scoreboard pops and structural invariants, sampled mid-cycle.
    logic prev_ack0 = 1'b0, prev_ack1 = 1'b0;
    logic last_ack = 1'b1, r1_waiting = 1'b0;
    always @(negedge clk) begin
        if (ack0) begin
            if (exp0_q.size() == 0) check_eq("ack0_unexpected", 32'd1, 32'd0);
            else check_eq("rdata0", rdata, exp0_q.pop_front());
            check_eq("ack0_pulse", {31'd0, prev_ack0}, 32'd0);
            if (last_ack == 1'b0) check_eq("no_double_ack0", {31'd0, r1_waiting}, 32'd0);
            last_ack   = 1'b0;
            r1_waiting = req1;
        end
        if (ack1) begin
            if (exp1_q.size() == 0) check_eq("ack1_unexpected", 32'd1, 32'd0);
            else check_eq("rdata1", rdata, exp1_q.pop_front());
            check_eq("ack1_pulse", {31'd0, prev_ack1}, 32'd0);
            last_ack = 1'b1;
        end
        if (ack0 && ack1) check_eq("ack_both", 32'd1, 32'd0);
        if (ram_w_en) check_eq("wen_busy", {31'd0, busy}, 32'd1);
        prev_ack0 = ack0;
        prev_ack1 = ack1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat0, lat1, n, guard;

        // Reset held two cycles with req0 asserted: everything stays quiet.
        set_req(0, 1'b1, 1'b0, 4'd7, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_ack0", {31'd0, ack0}, 32'd0);
            check_eq("rst_ack1", {31'd0, ack1}, 32'd0);
            check_eq("rst_wen", {31'd0, ram_w_en}, 32'd0);
            check_eq("rst_addr", {28'd0, ram_address}, 32'd0);
            check_eq("rst_rdata", rdata, 32'd0);
            check_eq("rst_busy", {31'd0, busy}, 32'd0);
        end
        set_req(0, 1'b0, 1'b0, 4'd0, 32'd0);
        rst = 1'b0;

        // Write 69 to address 12 from requester 0, with cycle-level checks.
        fork
            run_access(0, 1'b1, 4'd12, 32'd69, lat0);
            begin
                @(negedge clk);
                @(posedge clk); #2;
                check_eq("wr_wen", {31'd0, ram_w_en}, 32'd1);
                check_eq("wr_addr", {28'd0, ram_address}, 32'd12);
                check_eq("wr_din", ram_data_input, 32'd69);
                @(posedge clk); #2;
                check_eq("wr_wen_off", {31'd0, ram_w_en}, 32'd0);
            end
        join
        check_eq("wr_lat", lat0, 32'd2);

        // Read back through requester 1.
        fork
            run_access(1, 1'b0, 4'd12, 32'd0, lat1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check_eq("rd_wen", {31'd0, ram_w_en}, 32'd0);
                end
            end
        join
        check_eq("rd_lat", lat1, 32'd2);

        // Tie right after reset: requester 0 first.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        fork
            run_access(0, 1'b1, 4'd3, 32'h0000_000A, lat0);
            run_access(1, 1'b1, 4'd4, 32'h0000_000B, lat1);
        join
        check_eq("tie1_lat0", lat0, 32'd2);
        check_eq("tie1_lat1", lat1, 32'd5);

        // Requester 1 was served last, so the next tie goes to requester 0 again.
        fork
            run_access(0, 1'b0, 4'd4, 32'd0, lat0);
            run_access(1, 1'b0, 4'd3, 32'd0, lat1);
        join
        check_eq("tie2_lat0", lat0, 32'd2);
        check_eq("tie2_lat1", lat1, 32'd5);

        // After a lone requester-0 access, a tie goes to requester 1.
        run_access(0, 1'b0, 4'd12, 32'd0, lat0);
        fork
            run_access(0, 1'b0, 4'd3, 32'd0, lat0);
            run_access(1, 1'b0, 4'd12, 32'd0, lat1);
        join
        check_eq("tie3_lat1", lat1, 32'd2);
        check_eq("tie3_lat0", lat0, 32'd5);

        // Reset lands during ACCESS of a requester-1 read: no ack, then re-served.
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 4'd4, 32'd0);
        @(posedge clk); #1;
        check_eq("mid_busy_access", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_ack1", {31'd0, ack1}, 32'd0);
        check_eq("mid_wen", {31'd0, ram_w_en}, 32'd0);
        check_eq("mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp1_q.push_back(shadow[4]);
        n = 0;
        while (!ack1 && n < 32) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("mid_reserve_lat", n, 32'd2);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 4'd0, 32'd0);

        // Requester 0 streams continuously; requester 1 joins at a random cycle.
        fork
            begin
                @(negedge clk);
                set_req(0, 1'b1, 1'b0, 4'd3, 32'd0);
                exp0_q.push_back(shadow[3]);
                n = 0;
                guard = 0;
                while (n < 6 && guard < 200) begin
                    @(posedge clk); #1;
                    guard++;
                    if (ack0) begin
                        n++;
                        if (n < 6) exp0_q.push_back(shadow[3]);
                        else set_req(0, 1'b0, 1'b0, 4'd0, 32'd0);
                    end
                end
                check_eq("stream_acks", n, 32'd6);
            end
            begin
                repeat ($urandom_range(2, 6)) @(negedge clk);
                run_access(1, 1'b0, 4'd4, 32'd0, lat1);
                check_eq("starve_lat_le6", {31'd0, (lat1 <= 6)}, 32'd1);
            end
        join
        set_req(0, 1'b0, 1'b0, 4'd0, 32'd0);

        repeat (4) @(negedge clk);
        check_eq("exp0_drained", exp0_q.size(), 32'd0);
        check_eq("exp1_drained", exp1_q.size(), 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
